// File: rtl/vc_eq_arb_pkg.sv
// rtl/vc_eq_arb_pkg.sv - shared constants and helpers for the shared equality-compare arbiter
package vc_eq_arb_pkg;

  localparam int NREQ_MAX = 8;

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  // Minimum of 1 so that a 2-requester build still has a 1-bit ID.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_rr_arbiter.sv
// rtl/vc_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr and wraps
module vc_rr_arbiter
  import vc_eq_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic           found;
  logic [IDW-1:0] sel;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_eq_compare_arbiter.sv
// rtl/vc_eq_compare_arbiter.sv - NREQ requesters share one W-bit equality comparator
// through a round-robin arbiter and a one-entry ID-tagged response buffer.
module vc_eq_compare_arbiter
  import vc_eq_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*W-1:0] req_in0,
  input  logic [NREQ*W-1:0] req_in1,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic              resp_eq,
  output logic [IDW-1:0]    resp_id,
  output logic [CNTW-1:0]   match_cnt,
  output logic              busy
);

  // XOR, NOR-reduce each nibble, then AND the nibble results: shallow equality tree.
  function automatic logic eq_nib(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]   x;
    logic [W/4-1:0] nib;
    x = a ^ b;
    for (int i = 0; i < W/4; i++) nib[i] = ~|x[i*4 +: 4];
    return &nib;
  endfunction

  logic            state_q, state_d;
  logic            eq_q, eq_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  g_idx;
  logic [W-1:0]    op_a, op_b;
  logic            can_accept, req_fire, resp_fire;

  vc_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_val),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    g_idx = '0;
    op_a  = '0;
    op_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_idx = IDW'(i);
        op_a  = req_in0[i*W +: W];
        op_b  = req_in1[i*W +: W];
      end
    end
  end

  // req_rdy derives only from grant and buffer state, never from other rdy signals.
  assign can_accept = (state_q == EMPTY) | resp_rdy;
  assign req_rdy    = grant & {NREQ{can_accept}};
  assign req_fire   = |(req_val & req_rdy);
  assign resp_fire  = (state_q == FULL) & resp_rdy;

  always_comb begin
    state_d = state_q;
    eq_d    = eq_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (resp_fire && eq_q && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    if (req_fire) begin
      state_d = FULL;
      eq_d    = eq_nib(op_a, op_b);
      id_d    = g_idx;
      ptr_d   = (g_idx == IDW'(NREQ-1)) ? '0 : g_idx + 1'b1;
    end else if (resp_fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      eq_q    <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      eq_q    <= eq_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp_val  = (state_q == FULL);
  assign resp_eq   = eq_q;
  assign resp_id   = id_q;
  assign match_cnt = cnt_q;
  assign busy      = resp_val | (|req_val);

endmodule

// File: tb/tb_vc_eq_compare_arbiter.sv
// tb/tb_vc_eq_compare_arbiter.sv - directed self-checking bench for vc_eq_compare_arbiter
module tb_vc_eq_compare_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_val;
  logic [NREQ*W-1:0] req_in0, req_in1;
  logic              resp_rdy;

  logic [NREQ-1:0]   req_rdy, req_rdy_s;
  logic              resp_val, resp_val_s, resp_eq, resp_eq_s, busy, busy_s;
  logic [IDW-1:0]    resp_id, resp_id_s;
  logic [15:0]       match_cnt;
  logic [3:0]        match_cnt_s;

  int errors = 0;
  int checks = 0;

  vc_eq_compare_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_val(req_val), .req_rdy(req_rdy),
    .req_in0(req_in0), .req_in1(req_in1), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_eq(resp_eq), .resp_id(resp_id), .match_cnt(match_cnt), .busy(busy)
  );

  vc_eq_compare_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .req_val(req_val), .req_rdy(req_rdy_s),
    .req_in0(req_in0), .req_in1(req_in1), .resp_val(resp_val_s), .resp_rdy(resp_rdy),
    .resp_eq(resp_eq_s), .resp_id(resp_id_s), .match_cnt(match_cnt_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in0[i*W +: W] = a;
    req_in1[i*W +: W] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    req_val  = '0;
    resp_rdy = 1'b0;
    req_in0  = '0;
    req_in1  = '0;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (resp_val !== 1'b0) begin errors++; $display("FAIL reset_resp_val got=%0b exp=0", resp_val); end
    checks++; if (resp_eq !== 1'b0) begin errors++; $display("FAIL reset_resp_eq got=%0b exp=0", resp_eq); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id got=%0d exp=0", resp_id); end
    checks++; if (match_cnt !== 16'd0) begin errors++; $display("FAIL reset_match_cnt got=%0d exp=0", match_cnt); end
    checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_req_rdy got=%b exp=0000", req_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_single();
    req_val  = 4'b0100;
    resp_rdy = 1'b1;
    set_ops(2, 32'hDEADBEEF, 32'hDEADBEEF);
    #1;
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL single_req_rdy got=%b exp=0100", req_rdy); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%0b exp=1", busy); end
    cycle();
    req_val = '0;
    #1;
    checks++; if (resp_val !== 1'b1) begin errors++; $display("FAIL single_resp_val got=%0b exp=1", resp_val); end
    checks++; if (resp_eq !== 1'b1) begin errors++; $display("FAIL single_resp_eq got=%0b exp=1", resp_eq); end
    checks++; if (resp_id !== 2'd2) begin errors++; $display("FAIL single_resp_id got=%0d exp=2", resp_id); end
    checks++; if (match_cnt !== 16'd0) begin errors++; $display("FAIL single_cnt_before got=%0d exp=0", match_cnt); end
    cycle();
    #1;
    checks++; if (resp_val !== 1'b0) begin errors++; $display("FAIL single_drained got=%0b exp=0", resp_val); end
    checks++; if (match_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt_after got=%0d exp=1", match_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, W'(i), (i % 2 == 0) ? W'(i) : ~W'(i));
    req_val  = 4'b1111;
    resp_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      checks++; if (req_rdy !== exp_rdy) begin errors++; $display("FAIL rr_req_rdy k=%0d got=%b exp=%b", k, req_rdy, exp_rdy); end
      if (k >= 1) begin
        checks++; if (resp_val !== 1'b1) begin errors++; $display("FAIL rr_resp_val k=%0d got=%0b exp=1", k, resp_val); end
        checks++; if (resp_id !== IDW'((k-1) % 4)) begin errors++; $display("FAIL rr_resp_id k=%0d got=%0d exp=%0d", k, resp_id, (k-1) % 4); end
        checks++; if (resp_eq !== ((k-1) % 2 == 0)) begin errors++; $display("FAIL rr_resp_eq k=%0d got=%0b exp=%0b", k, resp_eq, ((k-1) % 2 == 0)); end
      end
      cycle();
    end
  endtask

  task automatic test_back_pressure();
    #1;
    checks++; if (match_cnt !== 16'd3) begin errors++; $display("FAIL bp_cnt_start got=%0d exp=3", match_cnt); end
    resp_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL bp_req_rdy k=%0d got=%b exp=0000", k, req_rdy); end
      checks++; if (resp_val !== 1'b1 || resp_id !== 2'd1 || resp_eq !== 1'b0)
        begin errors++; $display("FAIL bp_hold k=%0d got val=%0b id=%0d eq=%0b exp val=1 id=1 eq=0", k, resp_val, resp_id, resp_eq); end
      cycle();
    end
    resp_rdy = 1'b1;
    #1;
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL bp_ptr_kept got=%b exp=0100", req_rdy); end
    cycle();
    req_val = '0;
    #1;
    checks++; if (resp_val !== 1'b1 || resp_id !== 2'd2 || resp_eq !== 1'b1)
      begin errors++; $display("FAIL bp_refill got val=%0b id=%0d eq=%0b exp val=1 id=2 eq=1", resp_val, resp_id, resp_eq); end
    checks++; if (match_cnt !== 16'd3) begin errors++; $display("FAIL bp_cnt_mid got=%0d exp=3", match_cnt); end
    cycle();
    #1;
    checks++; if (resp_val !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle got val=%0b busy=%0b exp 0 0", resp_val, busy); end
    checks++; if (match_cnt !== 16'd4) begin errors++; $display("FAIL bp_cnt_end got=%0d exp=4", match_cnt); end
  endtask

  task automatic test_bit_diff();
    logic [W-1:0] base, one;
    base = 32'h5A3C96E1;
    one  = 32'h1;
    req_val  = 4'b0010;
    resp_rdy = 1'b1;
    for (int k = 0; k <= W; k++) begin
      set_ops(1, base, (k < W) ? (base ^ (one << k)) : base);
      cycle();
      #1;
      checks++; if (resp_eq !== (k == W) || resp_id !== 2'd1)
        begin errors++; $display("FAIL bitdiff k=%0d got eq=%0b id=%0d exp eq=%0b id=1", k, resp_eq, resp_id, (k == W)); end
    end
    req_val = '0;
    cycle();
  endtask

  task automatic test_saturation();
    do_reset();
    set_ops(0, 32'h0F0F1234, 32'h0F0F1234);
    req_val  = 4'b0001;
    resp_rdy = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    req_val = '0;
    cycle();
    #1;
    checks++; if (match_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got=%0d exp=15", match_cnt_s); end
    checks++; if (match_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16 got=%0d exp=20", match_cnt); end
  endtask

  task automatic test_reset_mid();
    set_ops(3, 32'h1, 32'h1);
    req_val  = 4'b1000;
    resp_rdy = 1'b0;
    cycle();
    #1;
    checks++; if (resp_val !== 1'b1 || resp_id !== 2'd3) begin errors++; $display("FAIL mid_full got val=%0b id=%0d exp val=1 id=3", resp_val, resp_id); end
    reset_n = 1'b0;
    #1;
    checks++; if (resp_val !== 1'b0) begin errors++; $display("FAIL mid_async_clear got=%0b exp=0", resp_val); end
    checks++; if (match_cnt !== 16'd0 || resp_id !== 2'd0) begin errors++; $display("FAIL mid_regs got cnt=%0d id=%0d exp 0 0", match_cnt, resp_id); end
    @(negedge clk);
    reset_n  = 1'b1;
    req_val  = 4'b1001;
    resp_rdy = 1'b1;
    set_ops(0, 32'h7, 32'h8);
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL mid_prio got=%b exp=0001", req_rdy); end
    cycle();
    #1;
    checks++; if (resp_val !== 1'b1 || resp_id !== 2'd0 || resp_eq !== 1'b0)
      begin errors++; $display("FAIL mid_resp got val=%0b id=%0d eq=%0b exp val=1 id=0 eq=0", resp_val, resp_id, resp_eq); end
    req_val = '0;
    cycle();
  endtask

  initial begin
    reset_n  = 1'b0;
    req_val  = '0;
    resp_rdy = 1'b0;
    req_in0  = '0;
    req_in1  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_bit_diff();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_eq_compare_arbiter.md
Name: vc_eq_compare_arbiter

Overview:
- Shares one 32-bit equality-compare datapath among NREQ requesters.
- Round-robin arbitration; val/rdy handshake on each request port and on a single response port.
- Comparator output registered into a one-entry response buffer tagged with the requester ID.
- Sits in front of the FFT control logic's address/tag checks, replacing per-requester comparators.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 32, operand width (multiple of 4)
- IDW, 2, requester ID width; must equal clog2(NREQ)
- CNTW, 16, match counter width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_val  input  NREQ  request valid, bit i = requester i
- req_rdy  output  NREQ  request ready, one-hot or zero
- req_in0  input  NREQ*W  operand A; requester i at bits [i*W +: W]
- req_in1  input  NREQ*W  operand B; same packing
- resp_val  output  1  response valid
- resp_rdy  input  1  response ready
- resp_eq  output  1  1 when the granted in0 equals the granted in1
- resp_id  output  IDW  requester index of the response
- match_cnt  output  CNTW  saturating count of accepted responses with eq=1
- busy  output  1  resp_val OR any req_val

Behaviour:
- Reset (async assert, sync-safe deassert):
  - resp_val=0, resp_eq=0, resp_id=0, match_cnt=0.
  - RR pointer=0; requester 0 has top priority.
- Response buffer has 2 states:
  - EMPTY (resp_val=0)
  - FULL (resp_val=1)
- can_accept = ~resp_val | resp_rdy. Pass-through on drain+fill in the same cycle is required.
- Arbitration (combinational):
  - Search starts at ptr and wraps modulo NREQ.
  - Grant goes to the first i with req_val[i]=1.
  - No grant when no req_val is set.
- req_rdy[i] = grant[i] & can_accept.
  - Ungranted requesters see rdy=0 regardless of can_accept.
  - req_rdy must not depend on other rdy signals, to avoid combinational loops.
- Request handshake fire = req_val[g] & req_rdy[g]. On fire:
  - resp_val<=1
  - resp_eq<=(in0_g==in1_g), compared over all W bits
  - resp_id<=g
  - ptr<=(g+1) mod NREQ
- Response handshake: resp_val & resp_rdy without fire -> resp_val<=0. resp_eq and resp_id hold their last values.
- FULL & ~resp_rdy:
  - resp_eq and resp_id are stable.
  - No req_rdy is asserted.
  - ptr does not move.
- Latency: request fire in cycle N gives resp_val=1 in cycle N+1. Throughput is 1 per cycle when resp_rdy=1.
- match_cnt increments on response fire with resp_eq=1. It saturates at all-ones and never wraps.
- Fairness: with all NREQ requesting continuously and resp_rdy=1, grant order is 0,1,..,NREQ-1,0,...
- Requesters may drop req_val before a grant. The arbiter must not latch stale requests.
- Asserting reset mid-transfer discards a buffered response. resp_val=0 in the same cycle (async).
- Equality is computed as the NOR-reduction of the XOR, in nibble groups of 4 bits then reduced. This is a timing structure; the function is plain equality.

Decomposition:
- Shared package vc_eq_arb_pkg holds:
  - NREQ_MAX=8
  - ID width function clog2
  - state localparams EMPTY=1'b0 and FULL=1'b1
- Sub-module vc_rr_arbiter (NREQ):
  - inputs: req, ptr
  - output: one-hot grant
  - purely combinational; reusable elsewhere
- Compare logic stays inline as a function.

Test Plan:
1. Reset, then requester 2 only, in0=in1=0xDEADBEEF, resp_rdy=1 -> req_rdy=4'b0100. Next cycle resp_val=1, resp_eq=1, resp_id=2; match_cnt=1 after the response fires.
2. All 4 requesting every cycle, in0=i, in1=i for even i and in1=~i for odd i, resp_rdy=1 -> resp_id sequence 0,1,2,3,0; resp_eq sequence 1,0,1,0,1; one response per cycle.
3. Back-pressure: resp_rdy=0 for 3 cycles while FULL, all requesting -> req_rdy=0000; resp_eq and resp_id stable; ptr unchanged. resp_rdy=1 -> drain and refill in the same cycle.
4. Single-bit difference in each nibble position 0..31 (in1 = in0 ^ (1<<k)) -> resp_eq=0 for every k; in1=in0 -> resp_eq=1.
5. Saturation with CNTW=4 and 20 matching responses -> match_cnt sticks at 15.
6. Reset mid-operation: assert reset_n=0 while resp_val=1 -> resp_val=0 immediately. After release, requester 0 wins over requester 3 when both request.
